alu_reservation_station: RTL and testbench

//  Receiving end of the decoder->ALU dispatch interface: buffers up to DEPTH decoded ALU ops
//  (RI/RR/LUI/AUIPC/JAL/JALR) with their operand tags and values.

---
 rtl/alu_reservation_station_if.sv | 42 ++++
 rtl/alu_reservation_station.sv | 180 ++++++++++++++++++
 tb/tb_alu_reservation_station.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_reservation_station_if.sv
// Decoder->ALU dispatch, dual CDB snoop and ALU issue bundle for the reservation station.
// master = decoder/CDB/execute side, slave = reservation station.
interface alu_reservation_station_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int OP_W   = 6,
    parameter int ADDR_W = 32
);
    localparam int DISP_W = TAG_W - 1 + 2 * (TAG_W + DATA_W) + OP_W;

    logic              alu_en;
    logic [DISP_W-1:0] alu_data;
    logic [ADDR_W-1:0] alu_pc;
    logic              flush;

    logic              cdb0_valid;
    logic [TAG_W-1:0]  cdb0_tag;
    logic [DATA_W-1:0] cdb0_data;
    logic              cdb1_valid;
    logic [TAG_W-1:0]  cdb1_tag;
    logic [DATA_W-1:0] cdb1_data;

    logic              rs_full;
    logic              ex_valid;
    logic [OP_W-1:0]   ex_op;
    logic [DATA_W-1:0] ex_a;
    logic [DATA_W-1:0] ex_b;
    logic [ADDR_W-1:0] ex_pc;
    logic [TAG_W-1:0]  ex_dest;

    modport master (
        output alu_en, alu_data, alu_pc, flush,
        output cdb0_valid, cdb0_tag, cdb0_data, cdb1_valid, cdb1_tag, cdb1_data,
        input  rs_full, ex_valid, ex_op, ex_a, ex_b, ex_pc, ex_dest
    );

    modport slave (
        input  alu_en, alu_data, alu_pc, flush,
        input  cdb0_valid, cdb0_tag, cdb0_data, cdb1_valid, cdb1_tag, cdb1_data,
        output rs_full, ex_valid, ex_op, ex_a, ex_b, ex_pc, ex_dest
    );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers DEPTH dispatched ops, wakes operands from two CDBs, issues oldest-index ready op.
// Latency: ready dispatch -> ex_valid two edges later; CDB wakeup -> ex_valid two edges after the broadcast.
// Backpressure: registered rs_full stalls the decoder; alu_en while full is dropped.
module alu_reservation_station #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int OP_W   = 6,
    parameter int ADDR_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    alu_reservation_station_if.slave  rs_if
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [TAG_W-1:0] TAG_FREE = {1'b1, {(TAG_W-1){1'b0}}};

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
    } opnd_t;

    // Field order mirrors the decoder packing, op in the LSBs.
    typedef struct packed {
        logic [TAG_W-2:0] rob_idx;
        opnd_t            src2;
        opnd_t            src1;
        logic [OP_W-1:0]  op;
    } disp_t;

    typedef struct packed {
        logic              vld;
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] pc;
        logic [TAG_W-1:0]  dest;
        opnd_t             src1;
        opnd_t             src2;
    } entry_t;

    entry_t            ent_q [DEPTH];
    entry_t            ent_n [DEPTH];
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_n;
    logic              rs_full_q;

    logic              ex_valid_q;
    logic [OP_W-1:0]   ex_op_q;
    logic [DATA_W-1:0] ex_a_q;
    logic [DATA_W-1:0] ex_b_q;
    logic [ADDR_W-1:0] ex_pc_q;
    logic [TAG_W-1:0]  ex_dest_q;

    disp_t             disp;
    logic              cdb0_ok;
    logic              cdb1_ok;
    logic              iss_vld;
    logic [IDX_W-1:0]  iss_idx;
    logic              free_found;
    logic [IDX_W-1:0]  free_idx;
    logic              dispatch;

    assign disp     = rs_if.alu_data;
    // A broadcast carrying the free tag can never name a producer.
    assign cdb0_ok  = rs_if.cdb0_valid & ~rs_if.cdb0_tag[TAG_W-1];
    assign cdb1_ok  = rs_if.cdb1_valid & ~rs_if.cdb1_tag[TAG_W-1];
    assign dispatch = rs_if.alu_en & ~rs_full_q & ~rs_if.flush & free_found;

    function automatic opnd_t wake(
        input opnd_t             o,
        input logic              v0,
        input logic [TAG_W-1:0]  t0,
        input logic [DATA_W-1:0] d0,
        input logic              v1,
        input logic [TAG_W-1:0]  t1,
        input logic [DATA_W-1:0] d1
    );
        opnd_t r;
        r = o;
        if (!o.tag[TAG_W-1]) begin
            if (v0 && (o.tag == t0)) begin
                r.tag = TAG_FREE;
                r.val = d0;
            end else if (v1 && (o.tag == t1)) begin
                r.tag = TAG_FREE;
                r.val = d1;
            end
        end
        return r;
    endfunction

    // Select and free-slot search both look only at registered state.
    always_comb begin
        iss_vld    = 1'b0;
        iss_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!iss_vld && ent_q[i].vld &&
                ent_q[i].src1.tag[TAG_W-1] && ent_q[i].src2.tag[TAG_W-1]) begin
                iss_vld = 1'b1;
                iss_idx = IDX_W'(i);
            end
            if (!free_found && !ent_q[i].vld) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_n[i]      = ent_q[i];
            ent_n[i].src1 = wake(ent_q[i].src1, cdb0_ok, rs_if.cdb0_tag, rs_if.cdb0_data,
                                 cdb1_ok, rs_if.cdb1_tag, rs_if.cdb1_data);
            ent_n[i].src2 = wake(ent_q[i].src2, cdb0_ok, rs_if.cdb0_tag, rs_if.cdb0_data,
                                 cdb1_ok, rs_if.cdb1_tag, rs_if.cdb1_data);
        end
        cnt_n = cnt_q + CNT_W'(dispatch) - CNT_W'(iss_vld);

        if (iss_vld) begin
            ent_n[iss_idx].vld = 1'b0;
        end

        // The issuing slot is valid, so it never collides with free_idx.
        if (dispatch) begin
            ent_n[free_idx].vld  = 1'b1;
            ent_n[free_idx].op   = disp.op;
            ent_n[free_idx].pc   = rs_if.alu_pc;
            ent_n[free_idx].dest = {1'b0, disp.rob_idx};
            ent_n[free_idx].src1 = wake(disp.src1, cdb0_ok, rs_if.cdb0_tag, rs_if.cdb0_data,
                                        cdb1_ok, rs_if.cdb1_tag, rs_if.cdb1_data);
            ent_n[free_idx].src2 = wake(disp.src2, cdb0_ok, rs_if.cdb0_tag, rs_if.cdb0_data,
                                        cdb1_ok, rs_if.cdb1_tag, rs_if.cdb1_data);
        end

        if (rs_if.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_n[i].vld = 1'b0;
            end
            cnt_n = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            cnt_q      <= '0;
            rs_full_q  <= 1'b0;
            ex_valid_q <= 1'b0;
            ex_op_q    <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_pc_q    <= '0;
            ex_dest_q  <= TAG_FREE;
        end else begin
            ent_q      <= ent_n;
            cnt_q      <= cnt_n;
            rs_full_q  <= (cnt_n == CNT_W'(DEPTH));
            ex_valid_q <= iss_vld & ~rs_if.flush;
            if (iss_vld && !rs_if.flush) begin
                ex_op_q   <= ent_q[iss_idx].op;
                ex_a_q    <= ent_q[iss_idx].src1.val;
                ex_b_q    <= ent_q[iss_idx].src2.val;
                ex_pc_q   <= ent_q[iss_idx].pc;
                ex_dest_q <= ent_q[iss_idx].dest;
            end
        end
    end

    assign rs_if.rs_full  = rs_full_q;
    assign rs_if.ex_valid = ex_valid_q;
    assign rs_if.ex_op    = ex_op_q;
    assign rs_if.ex_a     = ex_a_q;
    assign rs_if.ex_b     = ex_b_q;
    assign rs_if.ex_pc    = ex_pc_q;
    assign rs_if.ex_dest  = ex_dest_q;
endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: expected issues are queued at stimulus time
// and popped by a negedge monitor that also checks the exact issue cycle.
module tb_alu_reservation_station;
    localparam logic [3:0] TF = 4'b1000;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic [3:0]  dest;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    exp_t sb[$];

    alu_reservation_station_if #(.DATA_W(32), .TAG_W(4), .OP_W(6), .ADDR_W(32)) rif ();

    alu_reservation_station #(
        .DEPTH(8), .DATA_W(32), .TAG_W(4), .OP_W(6), .ADDR_W(32)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rs_if (rif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rif.ex_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_issue", {32'd0, rif.ex_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("issue_cycle", 64'(cyc), 64'(e.cyc));
                check("ex_op",   64'(rif.ex_op),   64'(e.op));
                check("ex_a",    64'(rif.ex_a),    64'(e.a));
                check("ex_b",    64'(rif.ex_b),    64'(e.b));
                check("ex_pc",   64'(rif.ex_pc),   64'(e.pc));
                check("ex_dest", 64'(rif.ex_dest), 64'(e.dest));
            end
        end
    end

    task automatic idle();
        rif.alu_en     = 1'b0;
        rif.alu_data   = '0;
        rif.alu_pc     = '0;
        rif.flush      = 1'b0;
        rif.cdb0_valid = 1'b0;
        rif.cdb0_tag   = TF;
        rif.cdb0_data  = '0;
        rif.cdb1_valid = 1'b0;
        rif.cdb1_tag   = TF;
        rif.cdb1_data  = '0;
    endtask

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            idle();
        end
    endtask

    task automatic disp(input logic [5:0] op, input logic [2:0] rob,
                        input logic [3:0] t1, input logic [31:0] d1,
                        input logic [3:0] t2, input logic [31:0] d2,
                        input logic [31:0] pc);
        rif.alu_en   = 1'b1;
        rif.alu_data = {rob, t2, d2, t1, d1, op};
        rif.alu_pc   = pc;
    endtask

    task automatic push(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [3:0] dest, input int c);
        exp_t e;
        e.op = op; e.a = a; e.b = b; e.pc = pc; e.dest = dest; e.cyc = c;
        sb.push_back(e);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        rst   = 1'b1;
        idle();
        repeat (3) @(negedge clk);
        check("rst_rs_full",  64'(rif.rs_full),  64'd0);
        check("rst_ex_valid", 64'(rif.ex_valid), 64'd0);
        check("rst_ex_op",    64'(rif.ex_op),    64'd0);
        check("rst_ex_a",     64'(rif.ex_a),     64'd0);
        check("rst_ex_b",     64'(rif.ex_b),     64'd0);
        check("rst_ex_pc",    64'(rif.ex_pc),    64'd0);
        check("rst_ex_dest",  64'(rif.ex_dest),  64'(TF));
        rst = 1'b0;
        step(2);

        // Both operands ready at dispatch.
        disp(6'd1, 3'd3, TF, 32'd5, TF, 32'd7, 32'h100);
        push(6'd1, 32'd5, 32'd7, 32'h100, 4'b0011, cyc + 2);
        step(4);

        // Operand 1 woken by cdb0 three cycles after dispatch.
        disp(6'd2, 3'd4, 4'd2, 32'd0, TF, 32'd9, 32'h104);
        step(3);
        rif.cdb0_valid = 1'b1; rif.cdb0_tag = 4'd2; rif.cdb0_data = 32'hDEAD;
        push(6'd2, 32'hDEAD, 32'd9, 32'h104, 4'd4, cyc + 2);
        step(4);

        // Dispatch bypass from cdb1 in the same cycle.
        disp(6'd3, 3'd5, 4'd5, 32'd0, TF, 32'd3, 32'h108);
        rif.cdb1_valid = 1'b1; rif.cdb1_tag = 4'd5; rif.cdb1_data = 32'h40;
        push(6'd3, 32'h40, 32'd3, 32'h108, 4'd5, cyc + 2);
        step(4);

        // Fill all entries pending on tag 1, overflow attempt, then a single wakeup.
        for (int i = 0; i < 8; i++) begin
            disp(6'(i + 8), 3'(i), 4'd1, 32'd0, TF, 32'h100 + 32'(i), 32'h2000 + 32'(4 * i));
            step();
        end
        check("full_after_8", 64'(rif.rs_full), 64'd1);
        disp(6'h3F, 3'd7, TF, 32'hBAD, TF, 32'hBAD, 32'hBAD0);
        step();
        check("full_after_drop", 64'(rif.rs_full), 64'd1);
        rif.cdb0_valid = 1'b1; rif.cdb0_tag = 4'd1; rif.cdb0_data = 32'hCAFE;
        for (int i = 0; i < 8; i++) begin
            push(6'(i + 8), 32'hCAFE, 32'h100 + 32'(i), 32'h2000 + 32'(4 * i), 4'(i), cyc + 2 + i);
        end
        step();
        check("full_before_issue", 64'(rif.rs_full), 64'd1);
        step();
        check("full_drop_at_issue", 64'(rif.rs_full), 64'd0);
        step(9);

        // Both buses carry tag 6: cdb0 wins.
        disp(6'd4, 3'd6, TF, 32'd1, 4'd6, 32'd0, 32'h10C);
        step();
        rif.cdb0_valid = 1'b1; rif.cdb0_tag = 4'd6; rif.cdb0_data = 32'h11;
        rif.cdb1_valid = 1'b1; rif.cdb1_tag = 4'd6; rif.cdb1_data = 32'h22;
        push(6'd4, 32'd1, 32'h11, 32'h10C, 4'd6, cyc + 2);
        step(4);

        // A free-tag broadcast must not wake anything.
        disp(6'd5, 3'd1, 4'd0, 32'd0, TF, 32'd2, 32'h110);
        step();
        rif.cdb0_valid = 1'b1; rif.cdb0_tag = TF; rif.cdb0_data = 32'h99;
        step(3);
        rif.cdb1_valid = 1'b1; rif.cdb1_tag = 4'd0; rif.cdb1_data = 32'h77;
        push(6'd5, 32'h77, 32'd2, 32'h110, 4'd1, cyc + 2);
        step(4);

        // Flush beats a same-cycle dispatch and a same-cycle issue.
        for (int i = 0; i < 4; i++) begin
            disp(6'd6, 3'(i), 4'd7, 32'd0, TF, 32'd0, 32'h300);
            step();
        end
        disp(6'd7, 3'd4, TF, 32'd1, TF, 32'd1, 32'h304);
        step();
        disp(6'd8, 3'd5, TF, 32'd2, TF, 32'd2, 32'h308);
        rif.flush = 1'b1;
        step();
        check("flush_ex_valid", 64'(rif.ex_valid), 64'd0);
        check("flush_rs_full",  64'(rif.rs_full),  64'd0);
        rif.cdb0_valid = 1'b1; rif.cdb0_tag = 4'd7; rif.cdb0_data = 32'h5;
        step(6);

        // Asynchronous reset mid-stream while full.
        for (int i = 0; i < 7; i++) begin
            disp(6'd9, 3'(i), 4'd7, 32'd0, TF, 32'd0, 32'h400);
            step();
        end
        disp(6'd10, 3'd7, TF, 32'd3, TF, 32'd4, 32'h41C);
        step();
        check("full_before_rst", 64'(rif.rs_full), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_rs_full",  64'(rif.rs_full),  64'd0);
        check("async_rst_ex_valid", 64'(rif.ex_valid), 64'd0);
        check("async_rst_ex_dest",  64'(rif.ex_dest),  64'(TF));
        check("async_rst_ex_a",     64'(rif.ex_a),     64'd0);
        @(negedge clk);
        rst = 1'b0;
        rif.cdb0_valid = 1'b1; rif.cdb0_tag = 4'd7; rif.cdb0_data = 32'h6;
        step(6);
        check("post_rst_rs_full", 64'(rif.rs_full), 64'd0);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
